neopixel_chain: RTL



---
 rtl/neopixel_chain.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/neopixel_chain.sv
// WS2812/SK6812 chain driver: serialises a buffered frame of GRB/GRBW pixels
// as one-wire NRZ bit cells followed by a latch low period.
module neopixel_chain #(
   parameter int unsigned CLOCK_SPEED_HZ = 32_000_000,
   parameter int unsigned NUM_PIXELS     = 8,
   parameter int unsigned BITS_PER_PIXEL = 24,
   parameter int unsigned T_SHORT        = CLOCK_SPEED_HZ / 3_333_333,
   parameter int unsigned T_LONG         = CLOCK_SPEED_HZ / 1_111_111,
   parameter int unsigned T_LATCH        = CLOCK_SPEED_HZ / 12_500,
   localparam int unsigned AW            = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      pixel_we,
   input  logic [AW-1:0]             pixel_addr,
   input  logic [BITS_PER_PIXEL-1:0] pixel_color,
   input  logic                      send_to_neopixels,
   output logic                      busy,
   output logic                      done,
   output logic                      one_wire
);

   localparam int unsigned T_MAX = (T_LONG > T_LATCH) ? T_LONG : T_LATCH;
   localparam int unsigned CW    = $clog2(T_MAX + 1);
   localparam int unsigned BW    = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

   localparam logic [CW-1:0] SHORT_M1 = CW'(T_SHORT - 1);
   localparam logic [CW-1:0] LONG_M1  = CW'(T_LONG - 1);
   localparam logic [CW-1:0] LATCH_M1 = CW'(T_LATCH - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);
   localparam logic [AW-1:0] PIX_LAST = AW'(NUM_PIXELS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_HIGH  = 3'd2;
   localparam logic [2:0] S_LOW   = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   logic [BITS_PER_PIXEL-1:0] r_buf [NUM_PIXELS];
   logic [2:0]                r_state;
   logic [CW-1:0]             r_cnt;
   logic [BW-1:0]             r_bit_idx;
   logic [AW-1:0]             r_pix_idx;
   logic [BITS_PER_PIXEL-1:0] r_shift;
   logic                      r_fin;

   logic [2:0]                w_state_nxt;
   logic [CW-1:0]             w_cnt_nxt;
   logic [BW-1:0]             w_bit_nxt;
   logic [AW-1:0]             w_pix_nxt;
   logic [BITS_PER_PIXEL-1:0] w_shift_nxt;
   logic                      w_fin_nxt;
   logic                      w_addr_ok;

   assign w_addr_ok = (32'(pixel_addr) < NUM_PIXELS);

   // Pixel buffer: writable at any time, deliberately not cleared by reset.
   always_ff @(posedge clock) begin
      if (pixel_we && w_addr_ok) begin
         r_buf[pixel_addr] <= pixel_color;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_pix_nxt   = r_pix_idx;
      w_shift_nxt = r_shift;
      w_fin_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A request coinciding with the done pulse is dropped.
            if (send_to_neopixels && !done) begin
               w_state_nxt = S_LOAD;
               w_pix_nxt   = '0;
            end
         end
         S_LOAD: begin
            w_shift_nxt = r_buf[r_pix_idx];
            w_bit_nxt   = '0;
            w_cnt_nxt   = r_buf[r_pix_idx][BITS_PER_PIXEL-1] ? LONG_M1 : SHORT_M1;
            w_state_nxt = S_HIGH;
         end
         S_HIGH: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_cnt_nxt   = r_shift[BITS_PER_PIXEL-1] ? SHORT_M1 : LONG_M1;
               w_state_nxt = S_LOW;
            end
         end
         S_LOW: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else if (r_bit_idx != BIT_LAST) begin
               w_shift_nxt = {r_shift[BITS_PER_PIXEL-2:0], 1'b0};
               w_bit_nxt   = r_bit_idx + BW'(1);
               w_cnt_nxt   = r_shift[BITS_PER_PIXEL-2] ? LONG_M1 : SHORT_M1;
               w_state_nxt = S_HIGH;
            end else if (r_pix_idx != PIX_LAST) begin
               w_pix_nxt   = r_pix_idx + AW'(1);
               w_state_nxt = S_LOAD;
            end else begin
               w_cnt_nxt   = LATCH_M1;
               w_state_nxt = S_LATCH;
            end
         end
         S_LATCH: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_fin_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered decodes of the current state, one clock behind it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_pix_idx <= '0;
         r_shift   <= '0;
         r_fin     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         one_wire  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_nxt;
         r_pix_idx <= w_pix_nxt;
         r_shift   <= w_shift_nxt;
         r_fin     <= w_fin_nxt;
         busy      <= (r_state != S_IDLE);
         done      <= r_fin;
         one_wire  <= (r_state == S_HIGH);
      end
   end

endmodule
